// File: rtl/pipe_pkg.sv
// Shared types and default sizes for the skid-buffered pipeline stage.
// State encoding doubles as the buffered-word count.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } skid_state_e;

  localparam int DEF_WIDTH = 160;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones.
// Ports: clk, reset (async active-low), inc, value.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register stage (main + skid) with valid/ready on both sides.
// Ports: clk, reset, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data, count, stall_cycles.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int CNT_W          = DEF_CNT_W,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count,
  output logic [CNT_W-1:0] stall_cycles
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q;
  logic             push, pop;

  assign push = in_valid && ready_q;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready comes from its own flop, computed from the next state,
  // so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != FULL);
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  // State encoding equals the number of buffered words.
  assign count     = 2'(state_q);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall (
    .clk  (clk),
    .reset(reset),
    .inc  (out_valid && !out_ready),
    .value(stall_cycles)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue model plus directed scenarios.
// Two instances share stimulus: default counter width and a 4-bit counter.
module tb_pipe_skid_reg;

  localparam int W = 160;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   count;
  logic [15:0]  stall_cycles;

  logic         in_ready4, out_valid4;
  logic [W-1:0] out_data4;
  logic [1:0]   count4;
  logic [3:0]   stall4;

  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] log_w[$];
  int           log_c[$];
  logic [W-1:0] last_w;
  bit           clr;
  int           stall_n;
  int           cyc_n = 0;

  pipe_skid_reg u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .stall_cycles(stall_cycles)
  );

  pipe_skid_reg #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .count(count4), .stall_cycles(stall4)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Queue model: words leave in push order, at most two held.
  always @(posedge clk or negedge reset) begin : model
    bit pu, po;
    if (!reset) begin
      q.delete();
      clr = 1'b1;
      last_w = '0;
      stall_n = 0;
    end else begin
      cyc_n++;
      if (q.size() > 0 && !out_ready) stall_n++;
      if (flush) begin
        q.delete();
        clr = 1'b1;
      end else begin
        pu = in_valid && (q.size() < 2);
        po = (q.size() > 0) && out_ready;
        if (po) begin
          last_w = q.pop_front();
          log_w.push_back(last_w);
          log_c.push_back(cyc_n);
          clr = 1'b0;
        end
        if (pu) q.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [W-1:0] ed;
    int s16, s4;
    ed  = (q.size() > 0) ? q[0] : (clr ? '0 : last_w);
    s16 = (stall_n > 65535) ? 65535 : stall_n;
    s4  = (stall_n > 15) ? 15 : stall_n;
    check("in_ready", W'(in_ready), W'(q.size() < 2));
    check("out_valid", W'(out_valid), W'(q.size() > 0));
    check("count", W'(count), W'(q.size()));
    check("out_data", out_data, ed);
    check("stall16", W'(stall_cycles), W'(s16));
    check("stall4", W'(stall4), W'(s4));
    check("out_valid4", W'(out_valid4), W'(q.size() > 0));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) cyc();
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_count", W'(count), W'(0));
    reset = 1'b1;

    // First word latency
    in_valid = 1'b1; in_data = W'(1); out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("lat_valid", W'(out_valid), W'(1));
    check("lat_data", out_data, W'(1));
    check("lat_count", W'(count), W'(1));
    cyc();
    log_w.delete(); log_c.delete();

    // Backpressure A,B,C
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = W'('hA);
    cyc();
    in_data = W'('hB);
    cyc();
    check("bp_in_ready", W'(in_ready), W'(0));
    check("bp_count", W'(count), W'(2));
    in_data = W'('hC);
    repeat (2) cyc();
    check("bp_hold_count", W'(count), W'(2));
    check("bp_hold_data", out_data, W'('hA));
    out_ready = 1'b1;
    cyc();
    cyc();
    in_valid = 1'b0;
    cyc();
    check("bp_npop", W'(log_w.size()), W'(3));
    if (log_w.size() == 3) begin
      check("bp_ord0", log_w[0], W'('hA));
      check("bp_ord1", log_w[1], W'('hB));
      check("bp_ord2", log_w[2], W'('hC));
    end
    log_w.delete(); log_c.delete();

    // Streaming 0..7
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    check("str_npop", W'(log_w.size()), W'(8));
    if (log_w.size() == 8) begin
      for (int i = 0; i < 8; i++) check("str_ord", log_w[i], W'(i));
      for (int i = 1; i < 8; i++)
        check("str_gap", W'(log_c[i] - log_c[i-1]), W'(1));
    end
    log_w.delete(); log_c.delete();

    // Flush while FULL with an incoming word
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = W'('h11);
    cyc();
    in_data = W'('h22);
    cyc();
    flush = 1'b1; in_data = W'('hDEAD);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count", W'(count), W'(0));
    check("fl_valid", W'(out_valid), W'(0));
    check("fl_data", out_data, W'(0));
    out_ready = 1'b1;
    repeat (3) cyc();
    check("fl_nopop", W'(log_w.size()), W'(0));

    // Stall counter saturation
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    in_valid = 1'b1; in_data = W'('h55); out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    repeat (20) cyc();
    check("sat4", W'(stall4), W'(15));
    check("sat16", W'(stall_cycles), W'(20));
    flush = 1'b1; out_ready = 1'b1;
    cyc();
    flush = 1'b0;
    check("sat4_flush", W'(stall4), W'(15));
    check("sat16_flush", W'(stall_cycles), W'(20));

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = W'('h66);
    cyc();
    in_data = W'('h77);
    cyc();
    in_valid = 1'b0;
    check("ar_full", W'(count), W'(2));
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid", W'(out_valid), W'(0));
    check("ar_count", W'(count), W'(0));
    check("ar_ready", W'(in_ready), W'(1));
    check("ar_data", out_data, W'(0));
    cyc();
    reset = 1'b1;

    // Mixed traffic against the model
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      in_data   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      cyc();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 160, payload bits per stage word (pc, instr, extImm, grf_rt, aluResult packed as 5x32).
REQ-002 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 Parameter CLEAR_ON_FLUSH, default 1; when 1, the data registers are zeroed on flush, and when 0 they keep stale contents.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; the asserting (falling) edge acts immediately and release is sampled on clk.
REQ-006 flush  input  1  synchronous clear of all buffered words (branch or exception kill).
REQ-007 in_valid  input  1  upstream word present on in_data.
REQ-008 in_ready  output  1  stage can accept a word this cycle; driven directly from a register.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  downstream accepts the word this cycle (replaces the old halt, with halt = !out_ready).
REQ-012 out_data  output  WIDTH  downstream payload, driven from the main register.
REQ-013 count  output  2  number of buffered words (0..2).
REQ-014 stall_cycles  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 A push occurs in a cycle where in_valid=1 and in_ready=1; a pop occurs where out_valid=1 and out_ready=1.
REQ-016 The stage has two registers: main (drives out_data) and skid.
REQ-017 States: EMPTY (count=0), ONE (main valid), FULL (main and skid valid).
REQ-018 In EMPTY, a push moves the state to ONE with main<=in_data; otherwise the state stays EMPTY.
REQ-019 In ONE, push with pop: stay ONE, main<=in_data.
REQ-020 In ONE, push without pop: go FULL, skid<=in_data, main unchanged.
REQ-021 In ONE, pop without push: go EMPTY.
REQ-022 In ONE with neither push nor pop: no change.
REQ-023 In FULL, in_ready=0, so no push can occur; a pop moves to ONE with main<=skid; otherwise no change.
REQ-024 in_ready SHALL equal 1 exactly when the state is not FULL.
REQ-025 out_valid SHALL equal 1 exactly when the state is not EMPTY.
REQ-026 Latency: a word pushed into EMPTY appears on out_data with out_valid=1 in the next cycle.
REQ-027 Sustained throughput SHALL be one word per cycle while out_ready=1.
REQ-028 Words SHALL leave in push order, with none lost or duplicated.
REQ-029 Flush dominates: the next state is EMPTY regardless of push or pop in the same cycle, and the incoming word is dropped.
REQ-030 If CLEAR_ON_FLUSH=1, flush also zeroes main and skid; out_data is 0 whenever the stage is EMPTY following reset or flush.
REQ-031 stall_cycles increments by 1 on each cycle with out_valid=1 and out_ready=0, holds at all-ones, is unaffected by flush, and is not wrapped.
REQ-032 out_data SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-033 While reset=0: state EMPTY, in_ready=1, out_valid=0, count=0, main=0, skid=0, stall_cycles=0.
REQ-034 A reset assertion in mid-operation SHALL discard all buffered words immediately, without waiting for a clock edge.

Structure
REQ-035 The shared package pipe_pkg holds the state typedef (EMPTY=2'b00, ONE=2'b01, FULL=2'b10) and the default WIDTH and CNT_W constants.
REQ-036 A single sub-module, sat_counter (parameter CNT_W; inputs clk, reset, inc; output value), implements stall_cycles.
REQ-037 There SHALL be no combinational path from out_ready to in_ready.

Verification
REQ-038 Reset release, then push A=0x1 with out_ready=1 -> next cycle out_valid=1, out_data=0x1, count=1.
REQ-039 out_ready=0 with pushes A, B, C offered -> A and B accepted, in_ready=0 after B, count=2; C is held upstream until the first pop; output order is A, B, C.
REQ-040 Continuous in_valid=1 and out_ready=1 for 8 words 0..7 -> 8 pops in 8 consecutive cycles, order preserved.
REQ-041 FULL with out_ready=0, then flush=1 together with in_valid=1 -> next cycle count=0, out_valid=0, out_data=0 (CLEAR_ON_FLUSH=1), and the input word is never output.
REQ-042 CNT_W=4 with out_valid=1 and out_ready=0 held for 20 cycles -> stall_cycles=15 (saturated); a later flush leaves it at 15.
REQ-043 reset pulled low asynchronously between clock edges while FULL -> out_valid=0 and count=0 immediately, before the next edge.
